irrigation_scheduler: RTL and testbench

IRRIGATION_SCHEDULER -- requirements
Module: irrigation_scheduler

---
 rtl/irrigation_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_irrigation_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_scheduler.sv
// Four-zone irrigation scheduler. Each scan compares every zone against low/high
// thresholds through an external 4-bit comparator and drives valves with hysteresis.
module irrigation_scheduler #(
   parameter int MAX_OPEN  = 2,
   parameter int MAX_SCANS = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] moisture,
   input  logic [3:0]  low_thr,
   input  logic [3:0]  high_thr,
   input  logic        fault_clr,
   output logic [3:0]  cmp_a,
   output logic [3:0]  cmp_b,
   input  logic        cmp_aeqb,
   input  logic        cmp_agtb,
   input  logic        cmp_altb,
   output logic [3:0]  valve,
   output logic        pump,
   output logic        scan_done,
   output logic        cfg_err,
   output logic [3:0]  fault,
   output logic [3:0]  deferred
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [2:0] OPEN_LIMIT = 3'(MAX_OPEN);
   localparam logic [7:0] SCAN_LIMIT = 8'(MAX_SCANS);

   state_t          state, state_nxt;
   logic [1:0]      zone, zone_nxt;
   logic [3:0][3:0] snap_moist;
   logic [3:0]      snap_low, snap_high;
   logic            lt, lt_nxt;
   logic [3:0][7:0] on_cnt, on_cnt_nxt;
   logic [3:0]      valve_nxt, deferred_nxt, fault_nxt, new_fault;
   logic            cfg_err_nxt, load, abort;
   logic [3:0]      zone_val;

   function automatic logic [2:0] count_open(input logic [3:0] v);
      count_open = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   assign zone_val = snap_moist[zone];
   assign abort    = (state != S_IDLE) && !enable;

   // Comparator operand selection, one comparison per cycle
   always_comb begin
      cmp_a = 4'd0;
      cmp_b = 4'd0;
      case (state)
         S_CHECK: begin cmp_a = snap_low; cmp_b = snap_high; end
         S_LOW:   begin cmp_a = zone_val; cmp_b = snap_low;  end
         S_HIGH:  begin cmp_a = zone_val; cmp_b = snap_high; end
         default: begin cmp_a = 4'd0;     cmp_b = 4'd0;      end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         zone  <= 2'd0;
      end else begin
         state <= state_nxt;
         zone  <= zone_nxt;
      end
   end

   // FSM next-state
   always_comb begin
      state_nxt = state;
      zone_nxt  = zone;
      if (abort) begin
         state_nxt = S_IDLE;
         zone_nxt  = 2'd0;
      end else begin
         case (state)
            S_IDLE:  begin state_nxt = enable ? S_CHECK : S_IDLE; zone_nxt = 2'd0; end
            S_CHECK: begin state_nxt = cmp_altb ? S_LOW : S_DONE; zone_nxt = 2'd0; end
            S_LOW:   begin state_nxt = S_HIGH; zone_nxt = zone; end
            S_HIGH:  begin
               if (zone == 2'd3) begin
                  state_nxt = S_DONE;
                  zone_nxt  = 2'd0;
               end else begin
                  state_nxt = S_LOW;
                  zone_nxt  = zone + 2'd1;
               end
            end
            S_DONE:  begin state_nxt = S_CHECK; zone_nxt = 2'd0; end
            default: begin state_nxt = S_IDLE; zone_nxt = 2'd0; end
         endcase
      end
   end

   // Valve, deferral, on-time and fault update
   always_comb begin
      valve_nxt    = valve;
      deferred_nxt = deferred;
      cfg_err_nxt  = cfg_err;
      on_cnt_nxt   = on_cnt;
      new_fault    = 4'b0000;
      lt_nxt       = lt;
      load         = 1'b0;
      if (abort) begin
         valve_nxt  = 4'b0000;
         on_cnt_nxt = '0;
      end else begin
         case (state)
            S_IDLE:  load = enable;
            S_CHECK: begin
               if (cmp_altb) begin
                  cfg_err_nxt = 1'b0;
               end else begin
                  cfg_err_nxt  = 1'b1;
                  valve_nxt    = 4'b0000;
                  deferred_nxt = 4'b0000;
               end
            end
            S_LOW:   lt_nxt = cmp_altb;
            S_HIGH:  begin
               if (valve[zone]) begin
                  if (cmp_agtb || cmp_aeqb) begin
                     valve_nxt[zone] = 1'b0;
                  end else begin
                     valve_nxt[zone] = 1'b1;
                  end
               end else if (lt && !fault[zone]) begin
                  // Open count is taken before this zone, so lower zones win contention
                  if (count_open(valve) < OPEN_LIMIT) begin
                     valve_nxt[zone]    = 1'b1;
                     deferred_nxt[zone] = 1'b0;
                  end else begin
                     deferred_nxt[zone] = 1'b1;
                  end
               end else begin
                  valve_nxt[zone] = 1'b0;
               end
            end
            S_DONE:  begin
               load = 1'b1;
               for (int i = 0; i < 4; i++) begin
                  if (valve[i]) begin
                     on_cnt_nxt[i] = on_cnt[i] + 8'd1;
                     if ((on_cnt[i] + 8'd1) == SCAN_LIMIT) begin
                        valve_nxt[i] = 1'b0;
                        new_fault[i] = 1'b1;
                     end else begin
                        new_fault[i] = 1'b0;
                     end
                  end else begin
                     on_cnt_nxt[i] = 8'd0;
                  end
               end
            end
            default: load = 1'b0;
         endcase
      end
      fault_nxt = (fault_clr ? 4'b0000 : fault) | new_fault;
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         valve      <= 4'b0000;
         pump       <= 1'b0;
         scan_done  <= 1'b0;
         cfg_err    <= 1'b0;
         fault      <= 4'b0000;
         deferred   <= 4'b0000;
         on_cnt     <= '0;
         lt         <= 1'b0;
         snap_moist <= '0;
         snap_low   <= 4'd0;
         snap_high  <= 4'd0;
      end else begin
         valve     <= valve_nxt;
         pump      <= |valve_nxt;
         scan_done <= (state_nxt == S_DONE);
         cfg_err   <= cfg_err_nxt;
         fault     <= fault_nxt;
         deferred  <= deferred_nxt;
         on_cnt    <= on_cnt_nxt;
         lt        <= lt_nxt;
         if (load) begin
            snap_moist <= moisture;
            snap_low   <= low_thr;
            snap_high  <= high_thr;
         end
      end
   end
endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed scenarios plus randomized scans checked
// against a scan-level behavioural model of the zone rules.
module tb_irrigation_scheduler;
   localparam int MAX_OPEN  = 2;
   localparam int MAX_SCANS = 3;

   logic        clk = 1'b0;
   logic        reset, enable, fault_clr;
   logic [15:0] moisture;
   logic [3:0]  low_thr, high_thr;
   logic [3:0]  cmp_a, cmp_b;
   logic        cmp_aeqb, cmp_agtb, cmp_altb;
   logic [3:0]  valve, fault, deferred;
   logic        pump, scan_done, cfg_err;

   int total = 0, passed = 0, failed = 0;

   // scan-level reference model
   logic [3:0] m_valve, m_fault, m_deferred;
   logic       m_cfg_err;
   int         m_cnt [4];
   bit         pending;
   logic [3:0] s_z [4];
   logic [3:0] s_lo, s_hi;

   always #5 clk = ~clk;

   // external shared comparator
   assign cmp_aeqb = (cmp_a == cmp_b);
   assign cmp_agtb = (cmp_a >  cmp_b);
   assign cmp_altb = (cmp_a <  cmp_b);

   irrigation_scheduler #(.MAX_OPEN(MAX_OPEN), .MAX_SCANS(MAX_SCANS)) dut (
      .clk(clk), .reset(reset), .enable(enable), .moisture(moisture),
      .low_thr(low_thr), .high_thr(high_thr), .fault_clr(fault_clr),
      .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_aeqb(cmp_aeqb), .cmp_agtb(cmp_agtb),
      .cmp_altb(cmp_altb), .valve(valve), .pump(pump), .scan_done(scan_done),
      .cfg_err(cfg_err), .fault(fault), .deferred(deferred)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int popc(input logic [3:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
   endfunction

   task automatic model_clear_all();
      m_valve = 4'b0; m_fault = 4'b0; m_deferred = 4'b0; m_cfg_err = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      pending = 0;
   endtask

   // zone rules applied to the first nz zones of the snapshot
   task automatic model_scan(input int nz);
      if (s_lo >= s_hi) begin
         m_cfg_err = 1'b1; m_valve = 4'b0; m_deferred = 4'b0;
      end else begin
         m_cfg_err = 1'b0;
         for (int i = 0; i < nz; i++) begin
            if (m_valve[i]) begin
               if (s_z[i] >= s_hi) m_valve[i] = 1'b0;
            end else if (s_z[i] < s_lo && !m_fault[i]) begin
               if (popc(m_valve) < MAX_OPEN) begin
                  m_valve[i] = 1'b1; m_deferred[i] = 1'b0;
               end else begin
                  m_deferred[i] = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic model_done(input logic clr);
      logic [3:0] nf;
      nf = 4'b0;
      for (int i = 0; i < 4; i++) begin
         if (m_valve[i]) begin
            m_cnt[i]++;
            if (m_cnt[i] == MAX_SCANS) begin m_valve[i] = 1'b0; nf[i] = 1'b1; end
         end else begin
            m_cnt[i] = 0;
         end
      end
      m_fault = (clr ? 4'b0 : m_fault) | nf;
   endtask

   task automatic scramble();
      moisture = 16'($urandom);
      low_thr  = 4'($urandom);
      high_thr = 4'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b1; fault_clr = 1'b1;
      scramble();
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      model_clear_all();
      chk("rst_valve", valve, 4'b0);     chk("rst_pump", pump, 1'b0);
      chk("rst_done", scan_done, 1'b0);  chk("rst_cfg", cfg_err, 1'b0);
      chk("rst_fault", fault, 4'b0);     chk("rst_defer", deferred, 4'b0);
      chk("rst_cmp", {cmp_a, cmp_b}, 8'h00);
      reset = 1'b0; enable = 1'b0; fault_clr = 1'b0;
      @(negedge clk);
   endtask

   // Runs one scan; called in a cycle whose next edge takes the snapshot.
   // abort_mode: 0 none, 1 enable drop in HIGH(2), 2 reset in HIGH(2).
   task automatic scan(input logic [15:0] m, input logic [3:0] lo, input logic [3:0] hi,
                       input logic clr, input int abort_mode);
      int cyc, exp_len, dones;
      moisture = m; low_thr = lo; high_thr = hi; enable = 1'b1; fault_clr = clr;
      @(posedge clk);
      if (pending) model_done(clr);
      else if (clr) m_fault = 4'b0;
      pending = 0;
      for (int i = 0; i < 4; i++) s_z[i] = m[4*i +: 4];
      s_lo = lo; s_hi = hi;
      @(negedge clk);
      fault_clr = 1'b0;
      cyc = 1;
      chk("chk_valve", valve, m_valve);
      chk("chk_pump", pump, |m_valve);
      chk("chk_fault", fault, m_fault);
      chk("chk_done_low", scan_done, 1'b0);
      exp_len = (lo < hi) ? 10 : 2;
      if (abort_mode != 0) begin
         while (cyc < 7) begin scramble(); @(negedge clk); cyc++; end
         if (abort_mode == 1) enable = 1'b0; else reset = 1'b1;
         model_scan(2);
         m_valve = 4'b0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         if (abort_mode == 2) model_clear_all();
         @(negedge clk);
         chk("abort_valve", valve, 4'b0);  chk("abort_pump", pump, 1'b0);
         chk("abort_done", scan_done, 1'b0);
         chk("abort_idle_cmp", {cmp_a, cmp_b}, 8'h00);
         chk("abort_fault", fault, m_fault);
         chk("abort_cfg", cfg_err, m_cfg_err);
         chk("abort_defer", deferred, m_deferred);
         reset = 1'b0; enable = 1'b0;
         dones = 0;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (scan_done === 1'b1 || {cmp_a, cmp_b} !== 8'h00) dones++;
         end
         chk("abort_stays_idle", dones, 0);
      end else begin
         while (scan_done !== 1'b1 && cyc < 30) begin scramble(); @(negedge clk); cyc++; end
         chk("scan_len", cyc, exp_len);
         model_scan(4);
         chk("scan_cfg", cfg_err, m_cfg_err);
         chk("scan_valve", valve, m_valve);
         chk("scan_defer", deferred, m_deferred);
         chk("scan_pump", pump, |m_valve);
         chk("open_limit", popc(valve) <= MAX_OPEN, 1'b1);
         pending = 1;
      end
   endtask

   initial begin
      logic [3:0] lo, hi;
      int ab;
      do_reset();

      // basic opening, hysteresis, max-on fault and fault clear
      scan(16'hC932, 4'd4, 4'd10, 1'b0, 0);
      chk("ex_open_0011", valve, 4'b0011);
      chk("ex_pump", pump, 1'b1);
      scan(16'hC936, 4'd4, 4'd10, 1'b0, 0);
      chk("ex_hyst_hold", valve, 4'b0011);
      scan(16'hC93A, 4'd4, 4'd10, 1'b0, 0);
      chk("ex_z0_close", valve, 4'b0010);
      scan(16'hC93A, 4'd4, 4'd10, 1'b0, 0);
      chk("ex_fault_set", fault, 4'b0010);
      chk("ex_z1_closed", valve, 4'b0000);
      scan(16'hC93A, 4'd4, 4'd10, 1'b1, 0);
      chk("ex_reopen", valve, 4'b0010);
      chk("ex_fault_clr", fault, 4'b0000);

      // capacity contention and deferral
      do_reset();
      scan(16'h1111, 4'd4, 4'd10, 1'b0, 0);
      chk("cap_valve", valve, 4'b0011);
      chk("cap_defer", deferred, 4'b1100);
      scan(16'h111F, 4'd4, 4'd10, 1'b0, 0);
      chk("cap_z2_open", valve, 4'b0110);
      chk("cap_defer2", deferred, 4'b1000);

      // configuration error and recovery
      scan(16'h5555, 4'd8, 4'd8, 1'b0, 0);
      chk("cfg_set", cfg_err, 1'b1);
      chk("cfg_closed", valve, 4'b0000);
      scan(16'h5555, 4'd8, 4'd12, 1'b0, 0);
      chk("cfg_clear", cfg_err, 1'b0);

      // aborts during HIGH(2)
      scan(16'h3210, 4'd4, 4'd10, 1'b0, 1);
      scan(16'h3210, 4'd4, 4'd10, 1'b0, 0);
      scan(16'h3210, 4'd4, 4'd10, 1'b0, 2);
      scan(16'h0000, 4'd4, 4'd10, 1'b0, 0);

      // randomized scans
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            lo = 4'($urandom); hi = 4'($urandom);
         end else begin
            lo = 4'($urandom_range(1, 12));
            hi = 4'($urandom_range(int'(lo) + 1, 15));
         end
         ab = (lo < hi && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
         scan(16'($urandom), lo, hi, 1'($urandom_range(0, 7) == 0), ab);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
